// File: rtl/arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Minimum step latencies are exported so callers can reason about CPU throughput.
package arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DM_REQ  = 3'd1,
    DM_RESP = 3'd2,
    IM_REQ  = 3'd3,
    IM_RESP = 3'd4,
    DONE    = 3'd5
  } arb_state_e;

  localparam int unsigned LAT_FETCH = 4;
  localparam int unsigned LAT_STORE = 5;
  localparam int unsigned LAT_LOAD  = 6;

endpackage

// File: rtl/mem_arb_perf.sv
// Step and stall-cycle counters for mem_arbiter; both wrap at 32 bits.
// Only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_done,
  input  logic        stall,
  output logic [31:0] perf_steps,
  output logic [31:0] perf_stall_cyc
);

  logic [31:0] steps_q, steps_d;
  logic [31:0] stall_cyc_q, stall_cyc_d;

  always_comb begin
    steps_d     = steps_q;
    stall_cyc_d = stall_cyc_q;
    if (step_done) steps_d     = steps_q + 32'd1;
    if (stall)     stall_cyc_d = stall_cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      steps_q     <= '0;
      stall_cyc_q <= '0;
    end else begin
      steps_q     <= steps_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign perf_steps     = steps_q;
  assign perf_stall_cyc = stall_cyc_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between CPU IM and DM: per step, optional DM access then IM fetch.
// Build macro MEM_ARB_PERF_EN enables the perf_steps / perf_stall_cyc counters.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_im_addr,
  input  logic              cpu_im_en,
  output logic [DATA_W-1:0] cpu_im_rdata,
  input  logic [ADDR_W-1:0] cpu_dm_addr,
  input  logic [DATA_W-1:0] cpu_dm_wdata,
  input  logic              cpu_dm_en,
  input  logic              cpu_dm_write,
  output logic [DATA_W-1:0] cpu_dm_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_steps,
  output logic [31:0]       perf_stall_cyc,
  output logic [2:0]        dbg_state
);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] im_rdata_q, im_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  // The fetch always happens, so the enable carries no information here.
  logic unused_im_en;
  assign unused_im_en = cpu_im_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      im_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      im_rdata_q <= im_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    im_rdata_d = im_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      IDLE:    state_d = cpu_dm_en ? DM_REQ : IM_REQ;
      DM_REQ:  if (mem_gnt) state_d = cpu_dm_write ? IM_REQ : DM_RESP;
      DM_RESP: if (mem_rvalid) begin
        dm_rdata_d = mem_rdata;
        state_d    = IM_REQ;
      end
      IM_REQ:  if (mem_gnt) state_d = IM_RESP;
      IM_RESP: if (mem_rvalid) begin
        im_rdata_d = mem_rdata;
        state_d    = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake: mem_req holds addr/we/wdata stable until a cycle with mem_gnt=1 accepts it;
  // a read's data returns later on mem_rvalid, a write completes on its grant.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst) begin
      unique case (state_q)
        DM_REQ: begin
          mem_req   = 1'b1;
          mem_we    = cpu_dm_write;
          mem_addr  = cpu_dm_addr;
          mem_wdata = cpu_dm_wdata;
        end
        IM_REQ: begin
          mem_req  = 1'b1;
          mem_addr = cpu_im_addr;
        end
        default: ;
      endcase
    end
    cpu_stall = !rst || (state_q != DONE);
  end

  assign cpu_im_rdata = im_rdata_q;
  assign cpu_dm_rdata = dm_rdata_q;
  assign dbg_state    = state_q;

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .step_done      (state_q == DONE),
    .stall          (rst && (state_q != DONE)),
    .perf_steps     (perf_steps),
    .perf_stall_cyc (perf_stall_cyc)
  );
`else
  assign perf_steps     = '0;
  assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with a request/step scoreboard and a scripted memory model.
// Build with MEM_ARB_PERF_EN defined to check the counters; otherwise they must read zero.
module tb_mem_arbiter;
  import arb_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int REQ_W = 1 + AW + DW;
  localparam int STP_W = DW + DW + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] cpu_im_addr  = '0;
  logic          cpu_im_en    = 1'b1;
  logic [DW-1:0] cpu_im_rdata;
  logic [AW-1:0] cpu_dm_addr  = '0;
  logic [DW-1:0] cpu_dm_wdata = '0;
  logic          cpu_dm_en    = 1'b0;
  logic          cpu_dm_write = 1'b0;
  logic [DW-1:0] cpu_dm_rdata;
  logic          cpu_stall;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic [31:0]   perf_steps, perf_stall_cyc;
  logic [2:0]    dbg_state;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_im_addr(cpu_im_addr), .cpu_im_en(cpu_im_en), .cpu_im_rdata(cpu_im_rdata),
    .cpu_dm_addr(cpu_dm_addr), .cpu_dm_wdata(cpu_dm_wdata), .cpu_dm_en(cpu_dm_en),
    .cpu_dm_write(cpu_dm_write), .cpu_dm_rdata(cpu_dm_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .perf_steps(perf_steps), .perf_stall_cyc(perf_stall_cyc), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [REQ_W-1:0] exp_q[$];
  logic [STP_W-1:0] exp_step_q[$];
  logic [DW-1:0]    rd_q[$];
  logic [DW-1:0]    exp_dm = '0;
  int done_cnt  = 0;
  int gnt_delay = 0;
  int rv_delay  = 0;
  bit spur      = 1'b0;

  task automatic check(input string name, input logic [STP_W-1:0] act, input logic [STP_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  initial begin
    bit rv_pending = 1'b0;
    int req_age = 0;
    int rv_age  = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!rst) begin
        rv_pending = 1'b0; req_age = 0; rd_q.delete();
      end else if (spur) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0; spur = 1'b0;
      end else if (rv_pending) begin
        if (rv_age >= rv_delay) begin
          mem_rvalid = 1'b1;
          mem_rdata  = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hFFFF_FFFF;
          rv_pending = 1'b0;
        end else rv_age++;
      end else if (mem_req) begin
        if (req_age >= gnt_delay) begin
          mem_gnt = 1'b1; req_age = 0;
          if (!mem_we) begin rv_pending = 1'b1; rv_age = 0; end
        end else req_age++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int step_cyc = 0;
    bit hold = 1'b0;
    logic [AW-1:0] hold_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        step_cyc = 0; hold = 1'b0;
      end else begin
        step_cyc++;
        if (hold) check("req_hold", {mem_req, mem_addr}, {1'b1, hold_addr});
        if (mem_req && mem_gnt) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_req: actual 0x%0h required none", mem_addr);
          end else check("mem_req", {mem_we, mem_addr, mem_wdata}, exp_q.pop_front());
        end
        hold = mem_req && !mem_gnt;
        hold_addr = mem_addr;
        if (!mem_req) check("idle_bus", {mem_we, mem_addr, mem_wdata}, '0);
        if (!cpu_stall) begin
          if (exp_step_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_step: actual len %0d required none", step_cyc);
          end else check("step", {cpu_im_rdata, cpu_dm_rdata, step_cyc[7:0]}, exp_step_q.pop_front());
          step_cyc = 0;
          done_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done();
    int start = done_cnt;
    int t = 0;
    while (done_cnt == start && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == start) begin
      tests++; fails++;
      $display("FAIL step_timeout: actual no DONE required DONE within 100 cycles");
    end
    #1;
  endtask

  task automatic do_step(input logic dm_en, input logic we, input logic [AW-1:0] dm_addr,
                         input logic [DW-1:0] wdata, input logic [AW-1:0] im_addr,
                         input logic [DW-1:0] dm_rd, input logic [DW-1:0] im_rd,
                         input int len, input int gd, input int rd);
    logic [7:0] len8;
    len8 = len[7:0];
    gnt_delay = gd; rv_delay = rd;
    cpu_dm_en = dm_en; cpu_dm_write = we; cpu_dm_addr = dm_addr;
    cpu_dm_wdata = wdata; cpu_im_addr = im_addr;
    if (dm_en) begin
      exp_q.push_back({we, dm_addr, wdata});
      if (!we) begin rd_q.push_back(dm_rd); exp_dm = dm_rd; end
    end
    exp_q.push_back({1'b0, im_addr, 32'h0});
    rd_q.push_back(im_rd);
    exp_step_q.push_back({im_rd, exp_dm, len8});
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, dbg_state, IDLE);
    check({tag, "_im_rdata"}, cpu_im_rdata, 0);
    check({tag, "_dm_rdata"}, cpu_dm_rdata, 0);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_stall"}, cpu_stall, 1);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b0;
    exp_q.delete(); exp_step_q.delete(); exp_dm = '0;
    repeat (n) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk); #1;
    apply_reset(2);

    // fetch-only, then load, store
    do_step(1'b0, 1'b0, 32'h0,    32'h0,        32'h1000_0000, 32'h0,        32'h0000_0013, LAT_FETCH, 0, 0);
    do_step(1'b1, 1'b0, 32'h8000, 32'h0,        32'h1000_0004, 32'hDEAD_BEEF, 32'h00A0_0093, LAT_LOAD, 0, 0);
    do_step(1'b1, 1'b1, 32'h8004, 32'h1234_5678, 32'h1000_0008, 32'h0,        32'h0010_0113, LAT_STORE, 0, 0);

    // backpressure on IM: gnt low 3 cycles, rvalid 2 cycles late
    do_step(1'b0, 1'b0, 32'h0,    32'h0,        32'h1000_000C, 32'h0,        32'h0020_8193, 9, 3, 2);

    // spurious rvalid in IDLE must not land anywhere
    spur = 1'b1;
    do_step(1'b0, 1'b0, 32'h0,    32'h0,        32'h1000_0010, 32'h0,        32'h0000_0073, LAT_FETCH, 0, 0);

    // load with backpressure on both accesses: 1+2+2+2+2+1
    do_step(1'b1, 1'b0, 32'h800C, 32'h5555_AAAA, 32'h1000_0014, 32'hCAFE_F00D, 32'h0040_0213, 10, 1, 1);

    // reset while the DM read is outstanding
    gnt_delay = 0; rv_delay = 5;
    cpu_dm_en = 1'b1; cpu_dm_write = 1'b0; cpu_dm_addr = 32'h8008;
    cpu_dm_wdata = 32'h0; cpu_im_addr = 32'h1000_0018;
    exp_q.push_back({1'b0, 32'h8008, 32'h0});
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_state", dbg_state, DM_RESP);
    apply_reset(1);
    do_step(1'b0, 1'b0, 32'h0,    32'h0,        32'h1000_001C, 32'h0,        32'h0050_0293, LAT_FETCH, 0, 0);

    // performance counters over three fetch-only steps
    apply_reset(2);
    do_step(1'b0, 1'b0, 32'h0, 32'h0, 32'h1000_0020, 32'h0, 32'h1111_1111, LAT_FETCH, 0, 0);
    do_step(1'b0, 1'b0, 32'h0, 32'h0, 32'h1000_0024, 32'h0, 32'h2222_2222, LAT_FETCH, 0, 0);
    do_step(1'b0, 1'b0, 32'h0, 32'h0, 32'h1000_0028, 32'h0, 32'h3333_3333, LAT_FETCH, 0, 0);
`ifdef MEM_ARB_PERF_EN
    check("perf_steps", perf_steps, 3);
    check("perf_stall_cyc", perf_stall_cyc, 9);
`else
    check("perf_steps_off", perf_steps, 0);
    check("perf_stall_off", perf_stall_cyc, 0);
`endif

    check("req_queue_drained", exp_q.size(), 0);
    check("step_queue_drained", exp_step_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
